// File: rtl/dfr_pkg.sv
// rtl/dfr_pkg.sv - shared types and helpers for the DFR run sequencer
// Purpose: FSM state enum, phase output encoding, 32-bit count type, and a
//          saturating increment used by every counter in the sequencer.
// Ports:   none (package).
package dfr_pkg;

    typedef logic [31:0] count_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_TRAIN = 3'd2,
        ST_TEST  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [1:0] PHASE_NONE  = 2'd0;
    localparam logic [1:0] PHASE_INIT  = 2'd1;
    localparam logic [1:0] PHASE_TRAIN = 2'd2;
    localparam logic [1:0] PHASE_TEST  = 2'd3;

    localparam count_t COUNT_MAX = '1;

    function automatic count_t sat_inc(input count_t v);
        return (v == COUNT_MAX) ? v : v + 32'd1;
    endfunction

    function automatic logic [1:0] state_to_phase(input state_e s);
        case (s)
            ST_INIT:  return PHASE_INIT;
            ST_TRAIN: return PHASE_TRAIN;
            ST_TEST:  return PHASE_TEST;
            default:  return PHASE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/dfr_step_counter.sv
// rtl/dfr_step_counter.sv - per-phase step/sample counter with limit detect
// Purpose: latches a phase's limits on load, counts accepted steps and
//          samples with saturation, and flags when the next accept ends the phase.
// Ports:   clk, rst       - clock, synchronous active-high reset
//          load           - phase entry: latch limits, clear counts
//          accept         - a step of this phase was accepted this cycle
//          *_lim_in, sps_in - sample limit, step limit, steps per sample
//          sample_idx, step_idx - current counts
//          limit_hit      - accepting now reaches the step or sample limit
module dfr_step_counter
    import dfr_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   accept,
    input  count_t sample_lim_in,
    input  count_t step_lim_in,
    input  count_t sps_in,
    output count_t sample_idx,
    output count_t step_idx,
    output logic   limit_hit
);

    count_t sample_lim_q, sample_lim_d;
    count_t step_lim_q, step_lim_d;
    count_t sps_q, sps_d;
    count_t sample_q, sample_d;
    count_t step_q, step_d;
    count_t intra_q, intra_d;
    count_t step_inc, sample_inc, intra_inc;
    logic   wrap;

    always_comb begin
        step_inc   = sat_inc(step_q);
        sample_inc = sat_inc(sample_q);
        intra_inc  = sat_inc(intra_q);
        // sps_q is never 0 after load, so a sample completes every sps_q steps
        wrap       = (intra_inc >= sps_q);
        limit_hit  = (step_inc >= step_lim_q) || (wrap && (sample_inc >= sample_lim_q));

        sample_lim_d = sample_lim_q;
        step_lim_d   = step_lim_q;
        sps_d        = sps_q;
        sample_d     = sample_q;
        step_d       = step_q;
        intra_d      = intra_q;

        if (load) begin
            sample_lim_d = sample_lim_in;
            step_lim_d   = step_lim_in;
            sps_d        = (sps_in == '0) ? 32'd1 : sps_in;
            sample_d     = '0;
            step_d       = '0;
            intra_d      = '0;
        end else if (accept) begin
            step_d = step_inc;
            if (wrap) begin
                intra_d  = '0;
                sample_d = sample_inc;
            end else begin
                intra_d = intra_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_lim_q <= '0;
            step_lim_q   <= '0;
            sps_q        <= '0;
            sample_q     <= '0;
            step_q       <= '0;
            intra_q      <= '0;
        end else begin
            sample_lim_q <= sample_lim_d;
            step_lim_q   <= step_lim_d;
            sps_q        <= sps_d;
            sample_q     <= sample_d;
            step_q       <= step_d;
            intra_q      <= intra_d;
        end
    end

    assign sample_idx = sample_q;
    assign step_idx   = step_q;

endmodule

// File: rtl/dfr_sequencer.sv
// rtl/dfr_sequencer.sv - init/train/test run sequencer issuing step requests
// Purpose: on start walks INIT -> TRAIN -> TEST -> DONE, skipping phases with
//          a zero limit, handshaking one step at a time via step_req/step_ack.
// Ports:   S_AXI_ACLK, rst  - clock, synchronous active-high reset
//          start            - one-cycle run request (honoured only in IDLE)
//          num_*_samples/steps, num_steps_per_sample - phase limits
//          step_ack         - datapath accepted the current step
//          abort            - end the run early (only with DFR_SEQ_ABORT_EN)
//          step_req, phase, sample_idx, step_idx, busy, done - status
// Build option: define DFR_SEQ_ABORT_EN to add the abort input.
module dfr_sequencer
    import dfr_pkg::*;
(
    input  logic        S_AXI_ACLK,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] num_init_samples,
    input  logic [31:0] num_train_samples,
    input  logic [31:0] num_test_samples,
    input  logic [31:0] num_init_steps,
    input  logic [31:0] num_train_steps,
    input  logic [31:0] num_test_steps,
    input  logic [31:0] num_steps_per_sample,
    input  logic        step_ack,
`ifdef DFR_SEQ_ABORT_EN
    input  logic        abort,
`endif
    output logic        step_req,
    output logic [1:0]  phase,
    output logic [31:0] sample_idx,
    output logic [31:0] step_idx,
    output logic        busy,
    output logic        done
);

    state_e     state_q, state_d;
    state_e     after_idle, after_init, after_train;
    logic       step_req_q, step_req_d;
    logic       busy_q, busy_d;
    logic       accept, abort_req, sel_hit;
    logic       ok_init, ok_train, ok_test;
    logic [1:0] cur_phase;
    count_t     lim_samples [3];
    count_t     lim_steps   [3];
    count_t     cnt_sample  [3];
    count_t     cnt_step    [3];
    logic [2:0] cnt_hit, cnt_load, cnt_accept;

`ifdef DFR_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign accept    = step_req_q && step_ack;
    assign cur_phase = state_to_phase(state_q);

    assign lim_samples[0] = num_init_samples;
    assign lim_samples[1] = num_train_samples;
    assign lim_samples[2] = num_test_samples;
    assign lim_steps[0]   = num_init_steps;
    assign lim_steps[1]   = num_train_steps;
    assign lim_steps[2]   = num_test_steps;

    // A phase with either limit at zero is skipped in the cycle it would be
    // entered, so each "after" target already resolves the whole skip chain.
    assign ok_init     = (num_init_samples != '0) && (num_init_steps != '0);
    assign ok_train    = (num_train_samples != '0) && (num_train_steps != '0);
    assign ok_test     = (num_test_samples != '0) && (num_test_steps != '0);
    assign after_train = ok_test  ? ST_TEST  : ST_DONE;
    assign after_init  = ok_train ? ST_TRAIN : after_train;
    assign after_idle  = ok_init  ? ST_INIT  : after_init;

    for (genvar i = 0; i < 3; i++) begin : g_cnt
        dfr_step_counter u_cnt (
            .clk           (S_AXI_ACLK),
            .rst           (rst),
            .load          (cnt_load[i]),
            .accept        (cnt_accept[i]),
            .sample_lim_in (lim_samples[i]),
            .step_lim_in   (lim_steps[i]),
            .sps_in        (num_steps_per_sample),
            .sample_idx    (cnt_sample[i]),
            .step_idx      (cnt_step[i]),
            .limit_hit     (cnt_hit[i])
        );
    end

    always_comb begin
        state_d    = state_q;
        sel_hit    = 1'b0;
        cnt_load   = '0;
        cnt_accept = '0;
        sample_idx = '0;
        step_idx   = '0;

        if (cur_phase != PHASE_NONE) begin
            sel_hit    = cnt_hit[cur_phase - 2'd1];
            sample_idx = cnt_sample[cur_phase - 2'd1];
            step_idx   = cnt_step[cur_phase - 2'd1];
        end

        case (state_q)
            ST_IDLE:  if (start) state_d = after_idle;
            ST_INIT:  if (abort_req) state_d = ST_DONE;
                      else if (accept && sel_hit) state_d = after_init;
            ST_TRAIN: if (abort_req) state_d = ST_DONE;
                      else if (accept && sel_hit) state_d = after_train;
            ST_TEST:  if (abort_req || (accept && sel_hit)) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Request is low on the entry cycle and for one cycle after each
        // accept, otherwise held until acknowledged.
        step_req_d = (cur_phase != PHASE_NONE) && (state_d == state_q) && !accept;
        busy_d     = (state_d != ST_IDLE);

        for (int i = 0; i < 3; i++) begin
            cnt_load[i]   = (state_d != state_q) && (state_to_phase(state_d) == 2'(i + 1));
            cnt_accept[i] = accept && (cur_phase == 2'(i + 1));
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            step_req_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_req_q <= step_req_d;
            busy_q     <= busy_d;
        end
    end

    assign step_req = step_req_q;
    assign busy     = busy_q;
    assign done     = (state_q == ST_DONE);
    assign phase    = cur_phase;

endmodule

// File: tb/tb_dfr_sequencer.sv
// tb/tb_dfr_sequencer.sv - scoreboard testbench for dfr_sequencer
module tb_dfr_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, step_ack;
    logic [31:0] n_init_s, n_train_s, n_test_s, n_init_t, n_train_t, n_test_t, n_sps;
    logic        step_req, busy, done;
    logic [1:0]  phase;
    logic [31:0] sample_idx, step_idx;
`ifdef DFR_SEQ_ABORT_EN
    logic        abort;
`endif

    always #5 clk = ~clk;

    dfr_sequencer dut (
        .S_AXI_ACLK           (clk),
        .rst                  (rst),
        .start                (start),
        .num_init_samples     (n_init_s),
        .num_train_samples    (n_train_s),
        .num_test_samples     (n_test_s),
        .num_init_steps       (n_init_t),
        .num_train_steps      (n_train_t),
        .num_test_steps       (n_test_t),
        .num_steps_per_sample (n_sps),
        .step_ack             (step_ack),
`ifdef DFR_SEQ_ABORT_EN
        .abort                (abort),
`endif
        .step_req             (step_req),
        .phase                (phase),
        .sample_idx           (sample_idx),
        .step_idx             (step_idx),
        .busy                 (busy),
        .done                 (done)
    );

    typedef struct packed {
        logic        is_done;
        logic [1:0]  phase;
        logic [31:0] sample;
        logic [31:0] step;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   acc_count = 0;
    int   done_count = 0;
    int   ack_age = 0;
    bit   saw_train = 1'b0;
    bit   saw_test = 1'b0;
    bit   spurious_ack = 1'b0;
    logic prev_req = 1'b0;

    task automatic check(input string name, input logic [66:0] act, input logic [66:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push_req(input logic [1:0] p, input int s, input int t);
        exp_q.push_back('{is_done: 1'b0, phase: p, sample: 32'(s), step: 32'(t)});
    endtask

    task automatic push_done();
        exp_q.push_back('{is_done: 1'b1, phase: 2'd0, sample: 32'd0, step: 32'd0});
    endtask

    // n accepts in phase p with k steps per sample: step i is in sample i/k
    task automatic push_phase(input logic [1:0] p, input int n, input int k);
        for (int i = 0; i < n; i++) push_req(p, i / k, i);
    endtask

    task automatic set_cfg(input int is_, input int it_, input int rs, input int rt,
                           input int ts, input int tt, input int sps);
        n_init_s = 32'(is_);  n_init_t = 32'(it_);
        n_train_s = 32'(rs);  n_train_t = 32'(rt);
        n_test_s = 32'(ts);   n_test_t = 32'(tt);
        n_sps = 32'(sps);
    endtask

    task automatic pulse_start();
        acc_count = 0;
        saw_train = 1'b0;
        saw_test  = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_cfg(input string tag, input bit restart);
        bit got;
        pulse_start();
        @(negedge clk);
        check({tag, "_busy_after_start"}, 67'(busy), 67'd1);
        if (restart) begin
            repeat (5) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        got = 1'b0;
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check({tag, "_done_seen"}, 67'(got), 67'd1);
        @(negedge clk);
        check({tag, "_busy_done_after"}, 67'({busy, done}), 67'd0);
        check({tag, "_queue_empty"}, 67'(exp_q.size()), 67'd0);
        exp_q.delete();
    endtask

    // Datapath model: acknowledge one cycle after each request appears.
    initial begin
        step_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (step_req) begin
                step_ack = (ack_age >= 1);
                ack_age++;
            end else begin
                step_ack = spurious_ack;
                ack_age  = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on every new request and every done pulse.
    always @(negedge clk) begin
        if (rst) begin
            prev_req = 1'b0;
        end else begin
            if (step_req && step_ack) acc_count++;
            if (phase == 2'd2) saw_train = 1'b1;
            if (phase == 2'd3) saw_test = 1'b1;
            if (step_req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_req: got phase %0d sample %0d step %0d, expected none",
                             phase, sample_idx, step_idx);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("scoreboard_req", {1'b0, phase, sample_idx, step_idx}, mon_e);
                end
            end
            if (done) begin
                done_count++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done pulse, expected none");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("scoreboard_done", {1'b1, 66'd0}, mon_e);
                end
            end
            prev_req = step_req;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1);
    end

    initial begin
        bit got;
        int done_base;
        rst = 1'b1;
        start = 1'b0;
`ifdef DFR_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        set_cfg(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 67'({step_req, busy, done, phase, sample_idx, step_idx}), 67'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Full run: 4 + 6 + 2 accepts, phases 1, 2, 3 in order
        set_cfg(2, 4, 3, 6, 1, 2, 2);
        push_phase(2'd1, 4, 2); push_phase(2'd2, 6, 2); push_phase(2'd3, 2, 2); push_done();
        run_cfg("full", 1'b0);
        check("full_accepts", 67'(acc_count), 67'd12);

        // Train step limit 0: TRAIN skipped
        set_cfg(2, 2, 3, 0, 1, 1, 1);
        push_phase(2'd1, 2, 1); push_phase(2'd3, 1, 1); push_done();
        run_cfg("skip", 1'b0);
        check("skip_accepts", 67'(acc_count), 67'd3);
        check("skip_no_train", 67'(saw_train), 67'd0);

        // Sample limit ends INIT first; train/test empty -> straight to DONE
        set_cfg(1, 10, 0, 0, 0, 0, 2);
        push_req(2'd1, 0, 0); push_req(2'd1, 0, 1); push_done();
        run_cfg("samplelim", 1'b0);
        check("samplelim_accepts", 67'(acc_count), 67'd2);

        // Start while busy and ack while step_req is low change nothing
        spurious_ack = 1'b1;
        set_cfg(2, 4, 3, 6, 1, 2, 2);
        push_phase(2'd1, 4, 2); push_phase(2'd2, 6, 2); push_phase(2'd3, 2, 2); push_done();
        run_cfg("noise", 1'b1);
        check("noise_accepts", 67'(acc_count), 67'd12);
        spurious_ack = 1'b0;

        // Reset during the third TRAIN step
        set_cfg(2, 4, 3, 6, 1, 2, 2);
        push_phase(2'd1, 4, 2); push_phase(2'd2, 3, 2);
        done_base = done_count;
        pulse_start();
        got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (step_req && phase == 2'd2 && step_idx == 32'd2) got = 1'b1;
        end
        check("rst_reach_step3", 67'(got), 67'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_outputs", 67'({step_req, busy, done, phase, sample_idx, step_idx}), 67'd0);
        repeat (20) @(negedge clk);
        check("rst_no_done", 67'(done_count - done_base), 67'd0);
        check("rst_queue_empty", 67'(exp_q.size()), 67'd0);
        exp_q.delete();

`ifdef DFR_SEQ_ABORT_EN
        // Abort in TRAIN at step_idx 3: done next cycle, TEST never entered
        set_cfg(2, 4, 3, 6, 1, 2, 2);
        push_phase(2'd1, 4, 2); push_phase(2'd2, 4, 2); push_done();
        pulse_start();
        got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (step_req && phase == 2'd2 && step_idx == 32'd3) got = 1'b1;
        end
        check("abort_reach_step3", 67'(got), 67'd1);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abort_done_pulse", 67'({done, step_req}), 67'b10);
        @(negedge clk);
        check("abort_busy_after", 67'({busy, done}), 67'd0);
        check("abort_no_test", 67'(saw_test), 67'd0);
        check("abort_queue_empty", 67'(exp_q.size()), 67'd0);
        exp_q.delete();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dfr_sequencer.md
DFR_SEQUENCER -- requirements
Module: dfr_sequencer

Interface
REQ-001 SHALL have port S_AXI_ACLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: one-cycle run request (ctrl bit 0).
REQ-004 SHALL have ports num_init_samples, num_train_samples and num_test_samples, each input, 32 bits: per-phase sample limit.
REQ-005 SHALL have ports num_init_steps, num_train_steps and num_test_steps, each input, 32 bits: per-phase step limit.
REQ-006 SHALL have port num_steps_per_sample, input, 32 bits: steps per input sample.
REQ-007 SHALL have port step_ack, input, 1 bit: datapath accepted the current step.
REQ-008 SHALL have port step_req, output, 1 bit: a step is requested.
REQ-009 SHALL have port phase, output, 2 bits: 0 = none, 1 = init, 2 = train, 3 = test.
REQ-010 SHALL have ports sample_idx and step_idx, each output, 32 bits: phase-local counters.
REQ-011 SHALL have port busy, output, 1 bit: a run is in progress (feeds ctrl bit 1).
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse at run end.
REQ-013 SHALL have port abort, input, 1 bit, present only when DFR_SEQ_ABORT_EN is defined.

Function
REQ-014 SHALL implement states IDLE, INIT, TRAIN, TEST, DONE.
REQ-015 SHALL go IDLE->INIT on start; start SHALL be ignored in every other state.
REQ-016 SHALL skip a phase, in the same cycle it would be entered, when its sample limit or its step limit is 0; the FSM then proceeds INIT->TRAIN->TEST->DONE.
REQ-017 SHALL assert step_req on the cycle after phase entry and hold it, with phase, sample_idx and step_idx stable, until step_ack.
REQ-018 SHALL, on a cycle with step_req and step_ack both high, increment step_idx at the edge and drop step_req for exactly one cycle.
REQ-019 SHALL increment sample_idx, and clear the intra-sample step count, every num_steps_per_sample accepted steps; num_steps_per_sample = 0 SHALL be treated as 1.
REQ-020 SHALL end a phase on the accept that makes step_idx equal the step limit or sample_idx equal the sample limit, whichever occurs first; no further step_req SHALL be issued in that phase.
REQ-021 SHALL clear sample_idx and step_idx to 0 on every phase entry.
REQ-022 SHALL ignore step_ack while step_req is low.
REQ-023 SHALL hold DONE for one cycle with done = 1, then return to IDLE.
REQ-024 SHALL drive busy = 1 in every state other than IDLE, registered, so the first busy cycle follows the start cycle.
REQ-025 SHALL sample the limit inputs when a phase is entered; changes during a phase SHALL have no effect on it.
REQ-026 SHALL use 32-bit unsigned counters that saturate, never wrapping.

Reset
REQ-027 SHALL, while rst is high, force state IDLE and drive all outputs to 0.
REQ-028 SHALL, on rst asserted mid-run, discard the step in flight without producing a done pulse.

Configuration
REQ-029 SHALL, with DFR_SEQ_ABORT_EN defined, make abort = 1 in INIT, TRAIN or TEST go to DONE the next cycle, drop step_req and pulse done; abort in IDLE or DONE SHALL be ignored.
REQ-030 SHALL, without DFR_SEQ_ABORT_EN, have no abort port and allow a run to end only through REQ-020 or reset.

Structure
REQ-031 SHALL place the state enum, the phase encoding constants and the 32-bit count type in the shared package dfr_pkg.
REQ-032 SHALL instantiate one sub-module, dfr_step_counter, three times via a phase-select mux; it provides step/sample counting with saturation and the limit-reached flag.

Verification
REQ-033 SHALL cover: limits init 2/4, train 3/6, test 1/2 (samples/steps), 2 steps per sample, ack one cycle after each request -> 4+6+2 accepts, phases 1,2,3 in order, a single done pulse, busy low the cycle after done.
REQ-034 SHALL cover: train steps = 0 -> TRAIN skipped, phase goes from 1 directly to 3.
REQ-035 SHALL cover: init samples = 1, init steps = 10, 2 steps per sample -> INIT ends after 2 accepts.
REQ-036 SHALL cover: start pulsed while busy, and ack driven while step_req is low -> no counter change and no extra request.
REQ-037 SHALL cover: rst asserted during the third TRAIN step -> next cycle state IDLE, all outputs 0, no done pulse.
REQ-038 SHALL cover: with DFR_SEQ_ABORT_EN, abort in TRAIN at step_idx = 3 -> done pulse 1 cycle later, TEST never entered.
